// File: rtl/nv_blkbox_chk_pkg.sv
// rtl/nv_blkbox_chk_pkg.sv - shared states, defaults and helpers for the tie-off checker
package nv_blkbox_chk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    FILTER = 2'd2,
    FAULT  = 2'd3
  } chk_state_e;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_FILTER_CYC = 4;
  localparam int DEF_CNT_W      = 8;

  // Increment that sticks at max_v instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/nv_blkbox_sync2.sv
// rtl/nv_blkbox_sync2.sv - two-flop synchronizer with a per-bit reset value
module nv_blkbox_sync2 #(
  parameter int WIDTH = 8
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rstn,
  input  logic [WIDTH-1:0] rst_val,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      meta <= rst_val;
      q    <= rst_val;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/nv_blkbox_tie_chk.sv
// rtl/nv_blkbox_tie_chk.sv - filtered sticky-fault checker for constant tie-off nets
module nv_blkbox_tie_chk
  import nv_blkbox_chk_pkg::*;
#(
  parameter int               WIDTH      = DEF_WIDTH,
  parameter logic [WIDTH-1:0] EXPECT     = '0,
  parameter int               FILTER_CYC = DEF_FILTER_CYC,
  parameter int               CNT_W      = DEF_CNT_W
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rstn,
  input  logic             chk_en,
  input  logic [WIDTH-1:0] tie_in,
  input  logic             err_clr,
  input  logic             intr_ack,
  output logic             err_flag,
  output logic [WIDTH-1:0] err_vec,
  output logic [CNT_W-1:0] err_cnt,
  output logic             intr_req
);

  localparam int              FCW     = (FILTER_CYC < 2) ? 1 : $clog2(FILTER_CYC);
  localparam logic [FCW-1:0]  FC_LAST = FCW'(FILTER_CYC - 1);
  localparam logic [31:0]     CNT_MAX = (CNT_W >= 32) ? 32'hFFFF_FFFF : ((32'd1 << CNT_W) - 32'd1);

  logic [WIDTH-1:0] tie_sync;
  logic             mism;
  chk_state_e       state_q, state_d;
  logic [FCW-1:0]   filt_cnt_q, filt_cnt_d;
  logic             fault_set, fault_clr;

  nv_blkbox_sync2 #(.WIDTH(WIDTH)) u_sync (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .rst_val         (EXPECT),
    .d               (tie_in),
    .q               (tie_sync)
  );

  assign mism = |(tie_sync ^ EXPECT);

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q    <= IDLE;
      filt_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      filt_cnt_q <= filt_cnt_d;
    end
  end

  // chk_en outranks mism while armed; in FAULT only err_clr leaves the state.
  always_comb begin
    state_d    = state_q;
    filt_cnt_d = filt_cnt_q;
    fault_set  = 1'b0;
    fault_clr  = 1'b0;
    case (state_q)
      IDLE: begin
        filt_cnt_d = '0;
        if (chk_en) state_d = ARMED;
      end
      ARMED: begin
        if (!chk_en) begin
          state_d    = IDLE;
          filt_cnt_d = '0;
        end else if (mism) begin
          if (FILTER_CYC == 1) begin
            state_d   = FAULT;
            fault_set = 1'b1;
          end else begin
            state_d    = FILTER;
            filt_cnt_d = FCW'(1);
          end
        end
      end
      FILTER: begin
        if (!chk_en) begin
          state_d    = IDLE;
          filt_cnt_d = '0;
        end else if (!mism) begin
          state_d    = ARMED;
          filt_cnt_d = '0;
        end else if (filt_cnt_q == FC_LAST) begin
          state_d   = FAULT;
          fault_set = 1'b1;
        end else begin
          filt_cnt_d = filt_cnt_q + FCW'(1);
        end
      end
      FAULT: begin
        if (err_clr) begin
          state_d    = ARMED;
          filt_cnt_d = '0;
          fault_clr  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      err_flag <= 1'b0;
      err_vec  <= '0;
      err_cnt  <= '0;
      intr_req <= 1'b0;
    end else begin
      if (fault_set) begin
        err_flag <= 1'b1;
        err_vec  <= tie_sync ^ EXPECT;
        err_cnt  <= CNT_W'(sat_inc(32'(err_cnt), CNT_MAX));
      end else if (fault_clr) begin
        err_flag <= 1'b0;
        err_vec  <= '0;
      end
      // A new fault outranks a same-cycle acknowledge.
      if (fault_set)     intr_req <= 1'b1;
      else if (intr_ack) intr_req <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nv_blkbox_tie_chk.sv
// tb/tb_nv_blkbox_tie_chk.sv - directed and randomized checks of nv_blkbox_tie_chk
module tb_nv_blkbox_tie_chk;
  import nv_blkbox_chk_pkg::*;

  localparam int W    = 8;
  localparam int FC   = 4;
  localparam int CW   = 2;
  localparam int CMAX = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          chk_en = 1'b0;
  logic [W-1:0]  tie_in = '0;
  logic          err_clr = 1'b0;
  logic          intr_ack = 1'b0;
  logic          err_flag;
  logic [W-1:0]  err_vec;
  logic [CW-1:0] err_cnt;
  logic          intr_req;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Reference: run = consecutive enabled mismatch samples since last arm/clear.
  logic [W-1:0] m_s1, m_s2, m_vec;
  logic         m_active, m_fault, m_flag, m_intr;
  int           m_run, m_cnt;

  always #5 clk = ~clk;

  nv_blkbox_tie_chk #(
    .WIDTH(W), .EXPECT('0), .FILTER_CYC(FC), .CNT_W(CW)
  ) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rst_n),
    .chk_en          (chk_en),
    .tie_in          (tie_in),
    .err_clr         (err_clr),
    .intr_ack        (intr_ack),
    .err_flag        (err_flag),
    .err_vec         (err_vec),
    .err_cnt         (err_cnt),
    .intr_req        (intr_req)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_vec = '0;
    m_active = 1'b0; m_fault = 1'b0; m_flag = 1'b0; m_intr = 1'b0;
    m_run = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    logic m;
    logic entered;
    m = (m_s2 != '0);
    entered = 1'b0;
    if (m_fault) begin
      if (err_clr) begin
        m_fault = 1'b0; m_run = 0; m_flag = 1'b0; m_vec = '0;
      end
    end else if (!m_active) begin
      m_run = 0;
      if (chk_en) m_active = 1'b1;
    end else if (!chk_en) begin
      m_active = 1'b0; m_run = 0;
    end else if (m) begin
      m_run++;
      if (m_run >= FC) begin
        entered = 1'b1;
        m_fault = 1'b1; m_flag = 1'b1; m_vec = m_s2;
        m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
      end
    end else begin
      m_run = 0;
    end
    if (entered)       m_intr = 1'b1;
    else if (intr_ack) m_intr = 1'b0;
    m_s2 = m_s1;
    m_s1 = tie_in;
  endtask

  task automatic check_all();
    chk("err_flag", 32'(err_flag), 32'(m_flag));
    chk("err_vec",  32'(err_vec),  32'(m_vec));
    chk("err_cnt",  32'(err_cnt),  32'(m_cnt));
    chk("intr_req", 32'(intr_req), 32'(m_intr));
  endtask

  task automatic cyc();
    if (rst_n) model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    model_reset();
    repeat (3) cyc();
    rst_n = 1'b1;

    // Quiet nets while enabled.
    chk_en = 1'b1;
    repeat (100) cyc();
    chk("state_armed", 32'(dut.state_q), 32'(ARMED));

    // Short glitch below the filter length.
    tie_in = 8'h04;
    repeat (3) cyc();
    tie_in = 8'h00;
    repeat (4) cyc();
    chk("glitch_filt0", 32'(dut.filt_cnt_q), 32'd0);
    chk("glitch_flag", 32'(err_flag), 32'd0);

    // Held mismatch confirms in cycle FILTER_CYC+2.
    tie_in = 8'h81;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      chk("lat_flag", 32'(err_flag), (i == 6) ? 32'd1 : 32'd0);
      chk("lat_intr", 32'(intr_req), (i == 6) ? 32'd1 : 32'd0);
    end
    chk("vec_81", 32'(err_vec), 32'h81);
    chk("cnt_1", 32'(err_cnt), 32'd1);

    // Acknowledge, then clear with the mismatch still present.
    intr_ack = 1'b1; cyc(); intr_ack = 1'b0;
    chk("ack_intr0", 32'(intr_req), 32'd0);
    chk("ack_flag1", 32'(err_flag), 32'd1);
    err_clr = 1'b1; cyc(); err_clr = 1'b0;
    chk("clr_flag0", 32'(err_flag), 32'd0);
    chk("clr_vec0", 32'(err_vec), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      chk("refault_flag", 32'(err_flag), (i == 4) ? 32'd1 : 32'd0);
    end
    chk("cnt_2", 32'(err_cnt), 32'd2);

    // Saturation, with each re-fault landing on an acknowledge.
    for (int k = 0; k < 5; k++) begin
      err_clr = 1'b1; cyc(); err_clr = 1'b0;
      repeat (3) cyc();
      intr_ack = 1'b1; cyc(); intr_ack = 1'b0;
      chk("entry_vs_ack", 32'(intr_req), 32'd1);
    end
    chk("cnt_sat", 32'(err_cnt), 32'd3);
    intr_ack = 1'b1; cyc(); intr_ack = 1'b0;
    chk("ack_clear", 32'(intr_req), 32'd0);
    intr_ack = 1'b1; cyc(); intr_ack = 1'b0;
    chk("ack_idle", 32'(intr_req), 32'd0);

    // Asynchronous reset two cycles into FILTER.
    err_clr = 1'b1; cyc(); err_clr = 1'b0;
    tie_in = 8'hFF;
    repeat (2) cyc();
    chk("mid_filt", 32'(dut.filt_cnt_q), 32'd2);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    chk("rst_sync", 32'(dut.tie_sync), 32'd0);
    repeat (2) cyc();
    chk_en = 1'b0;
    rst_n = 1'b1;
    repeat (50) cyc();
    chk("dis_no_fault", 32'(err_flag), 32'd0);
    tie_in = 8'h00;
    repeat (3) cyc();

    // Randomized traffic with bursts of single-bit and multi-bit deviations.
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 2)      tie_in = W'(1 << $urandom_range(0, W - 1));
      else if (r < 3) tie_in = W'($urandom);
      else if (r < 7) tie_in = tie_in;
      else            tie_in = '0;
      chk_en   = ($urandom_range(0, 19) != 0);
      err_clr  = ($urandom_range(0, 11) == 0);
      intr_ack = ($urandom_range(0, 7) == 0);
      cyc();
    end
    err_clr = 1'b0;
    intr_ack = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/nv_blkbox_tie_chk.md
Name: nv_blkbox_tie_chk

Overview:
Consumer-side checker for tie-off blackbox sources such as constant-0 and constant-1 cells. It samples a vector of tie-off nets that should be constant, filters transient mismatches, and raises a sticky fault with interrupt handshake when any bit deviates from its expected constant. It sits beside tie-off consumers in the core clock domain and feeds the error/interrupt aggregation logic.

Parameters:
WIDTH, 8, number of monitored tie-off nets
EXPECT, {WIDTH{1'b0}}, expected constant per bit (0 matches a tie-low source)
FILTER_CYC, 4, consecutive mismatch cycles needed to confirm a fault; legal range >=1
CNT_W, 8, width of the confirmed-fault counter

Ports:
nvdla_core_clk  input  1  core clock; sole clock
nvdla_core_rstn  input  1  reset, asynchronous assert, active-low
chk_en  input  1  checker enable, level
tie_in  input  WIDTH  monitored tie-off nets; treated as asynchronous
err_clr  input  1  single-cycle pulse; clears a sticky fault
intr_ack  input  1  single-cycle pulse; acknowledges intr_req
err_flag  output  1  sticky confirmed-fault flag
err_vec  output  WIDTH  mismatch pattern (tie_sync ^ EXPECT) captured at fault confirmation
err_cnt  output  CNT_W  count of confirmed faults since reset, saturating
intr_req  output  1  interrupt request; level, held until acknowledged

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low (nvdla_core_clk, nvdla_core_rstn).
- Reset values: err_flag=0, err_vec=0, err_cnt=0, intr_req=0, sync flops=EXPECT, filt_cnt=0, state=IDLE.
- tie_in passes through a 2-flop synchronizer (tie_sync). The synchronizer runs regardless of chk_en.
- mism = |(tie_sync ^ EXPECT).
- FSM states:
  - IDLE: chk_en=0; filt_cnt held at 0.
  - ARMED: enabled, no mismatch.
  - FILTER: counting consecutive mismatches.
  - FAULT: sticky fault.
- FSM transitions:
  - IDLE -> ARMED when chk_en=1.
  - ARMED -> FILTER when mism=1; filt_cnt<=1.
  - FILTER: mism=0 -> ARMED, filt_cnt<=0.
  - FILTER: mism=1 and filt_cnt==FILTER_CYC-1 -> FAULT.
  - FILTER: otherwise filt_cnt++.
  - If FILTER_CYC==1: ARMED with mism=1 goes directly to FAULT.
  - ARMED/FILTER with chk_en=0 -> IDLE, filt_cnt<=0. chk_en has priority over mism.
  - FAULT: err_clr=1 -> ARMED, filt_cnt<=0. chk_en is ignored in FAULT (fault is sticky).
- Actions on entry to FAULT (registered, same edge):
  - err_flag<=1.
  - err_vec<=tie_sync^EXPECT.
  - err_cnt++, saturating at 2^CNT_W-1.
  - intr_req<=1.
- Latency: tie_in held mismatching from cycle 0 -> err_flag and intr_req high in cycle FILTER_CYC+2.
- err_clr in FAULT: err_flag<=0 and err_vec<=0 next cycle. err_cnt and intr_req are unaffected.
- err_clr outside FAULT has no effect.
- If the mismatch persists after a clear, the fault re-confirms after FILTER_CYC more cycles and err_cnt increments again.
- intr_req:
  - intr_ack clears it next cycle.
  - A FAULT entry in the same cycle as intr_ack wins; intr_req stays 1.
  - intr_ack while intr_req=0 is ignored.
- Reset asserted mid-FILTER or mid-FAULT immediately forces all reset values. The synchronizer reloads EXPECT, so there are no spurious faults after reset.
- Per-bit glitches on different bits still count as consecutive mismatches; mism is an aggregate OR.

Decomposition:
- Package nv_blkbox_chk_pkg:
  - state enum {IDLE, ARMED, FILTER, FAULT} (2-bit encoding);
  - default parameter constants;
  - a saturating-increment function.
- Sub-module nv_blkbox_sync2: parameterised-width 2-flop synchronizer with reset value input, on nvdla_core_clk/nvdla_core_rstn.
- The FSM, counters and interrupt logic stay in the top module.

Test Plan:
1. Defaults, chk_en=1, tie_in=0 for 100 cycles -> err_flag=0, intr_req=0, err_cnt=0, state ARMED.
2. tie_in=8'h04 for 3 cycles, then 0 -> no fault; filt_cnt returns to 0; err_flag stays 0.
3. tie_in=8'h81 held -> err_flag=1, intr_req=1 in cycle 6; err_vec=8'h81; err_cnt=1.
4. From scenario 3: intr_ack pulse -> intr_req=0, err_flag stays 1. Then err_clr with tie_in still 8'h81 -> err_flag=0 for 4 cycles, then re-fault; err_cnt=2.
5. CNT_W=2, 5 fault/clear cycles -> err_cnt saturates at 3. A fault entry coinciding with intr_ack keeps intr_req=1.
6. Reset mid-FILTER (tie_in=8'hFF, 2 cycles in) -> all outputs 0 immediately. With chk_en=0 and tie_in=8'hFF -> no fault ever.
